// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential radix-2 restoring divider. A 2*WIDTH-bit dividend is divided by a
// WIDTH-bit divisor, producing a WIDTH-bit quotient and remainder. One quotient
// bit is resolved per clock, so a normal division completes WIDTH+1 edges after
// the accepting edge. Divide-by-zero and quotient-overflow cases are detected
// on the accepting edge and complete one edge later.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   undefined : operands and results are unsigned.
//   defined   : operands are two's complement; the core runs on magnitudes and
//               the sign is restored in the FIX state (truncation toward zero,
//               remainder takes the dividend's sign).
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous active-high reset
//   start        in   1        request a division (honoured in IDLE/DONE only)
//   dividend     in   2*WIDTH  dividend, captured on the accepting edge
//   divisor      in   WIDTH    divisor, captured on the accepting edge
//   quotient     out  WIDTH    registered quotient
//   remainder    out  WIDTH    registered remainder
//   ready        out  1        idle/done with valid result; low while busy
//   div_by_zero  out  1        last operation had divisor == 0
//   overflow     out  1        last operation's quotient did not fit
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]       divisor,
    output logic [WIDTH-1:0]       quotient,
    output logic [WIDTH-1:0]       remainder,
    output logic                   ready,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e              r_state;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_prem;      // partial remainder
    logic [WIDTH-1:0]    r_acc;       // low dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0]    r_divisor;   // divisor magnitude
    logic                r_pre;       // result was decided on the accepting edge
    logic                r_pre_dbz;
    logic                r_pre_ovf;
    logic [WIDTH-1:0]    r_quotient;
    logic [WIDTH-1:0]    r_remainder;
    logic                r_ready;
    logic                r_dbz;
    logic                r_ovf;

    // -------------------------------------------------------------------------
    // Operand magnitudes and preflight decisions
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]    w_dvs_mag;
    logic                w_dbz;
    logic                w_pre_ovf;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [2*WIDTH-1:0] ONE_D   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    // Largest magnitude a negative quotient may have: 2^(WIDTH-1).
    localparam logic [WIDTH-1:0]   MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_q_neg;
    logic r_r_neg;

    assign w_dvd_neg = dividend[2*WIDTH-1];
    assign w_dvs_neg = divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + ONE_D) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + ONE_W) : divisor;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    assign w_dbz     = (w_dvs_mag == '0);
    // With a non-zero divisor, a high half >= divisor means the quotient
    // needs more than WIDTH bits.
    assign w_pre_ovf = (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag);

    // -------------------------------------------------------------------------
    // One restoring step
    // -------------------------------------------------------------------------
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_trial;
    logic                w_qbit;
    logic [WIDTH-1:0]    w_prem_next;
    logic [WIDTH-1:0]    w_acc_next;

    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and a non-negative difference fits WIDTH bits.
    // The MSB of the WIDTH+1-bit difference is therefore a clean sign bit.
    assign w_shift     = {r_prem, r_acc[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_divisor};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_prem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_acc_next  = {r_acc[WIDTH-2:0], w_qbit};

    // -------------------------------------------------------------------------
    // Result formation for the FIX state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]    w_fix_q;
    logic [WIDTH-1:0]    w_fix_r;
    logic                w_fix_ovf;

    always_comb begin
        w_fix_q   = r_acc;
        w_fix_r   = r_prem;
        w_fix_ovf = 1'b0;
        if (r_pre) begin
            // Preflight already loaded the final quotient/remainder.
            w_fix_ovf = r_pre_ovf;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (r_q_neg ? (r_acc > MIN_MAG) : r_acc[WIDTH-1]) begin
                w_fix_q   = '1;
                w_fix_r   = '0;
                w_fix_ovf = 1'b1;
            end else begin
                w_fix_q = r_q_neg ? (~r_acc + ONE_W) : r_acc;
                w_fix_r = r_r_neg ? (~r_prem + ONE_W) : r_prem;
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and all state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_prem      <= '0;
            r_acc       <= '0;
            r_divisor   <= '0;
            r_pre       <= 1'b0;
            r_pre_dbz   <= 1'b0;
            r_pre_ovf   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ready     <= 1'b1;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_divisor <= w_dvs_mag;
                        r_count   <= '0;
                        r_ready   <= 1'b0;
                        r_dbz     <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_pre_dbz <= w_dbz;
                        r_pre_ovf <= ~w_dbz & w_pre_ovf;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg   <= w_dvd_neg;
`endif
                        if (w_dbz) begin
                            r_pre   <= 1'b1;
                            r_acc   <= '1;
                            r_prem  <= dividend[WIDTH-1:0];
                            r_state <= StFix;
                        end else if (w_pre_ovf) begin
                            r_pre   <= 1'b1;
                            r_acc   <= '1;
                            r_prem  <= '0;
                            r_state <= StFix;
                        end else begin
                            r_pre   <= 1'b0;
                            r_prem  <= w_dvd_mag[2*WIDTH-1:WIDTH];
                            r_acc   <= w_dvd_mag[WIDTH-1:0];
                            r_state <= StRun;
                        end
                    end
                end

                StRun: begin
                    r_prem <= w_prem_next;
                    r_acc  <= w_acc_next;
                    if (r_count == CNT_LAST) begin
                        r_count <= '0;
                        r_state <= StFix;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end

                StFix: begin
                    r_quotient  <= w_fix_q;
                    r_remainder <= w_fix_r;
                    r_dbz       <= r_pre_dbz;
                    r_ovf       <= w_fix_ovf;
                    r_ready     <= 1'b1;
                    r_state     <= StDone;
                end

                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign ready       = r_ready;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed self-checking bench for seq_divider at WIDTH=8. Each scenario task
// drives its own stimulus and compares against hand-computed values. Scenarios
// that only make sense for unsigned operands are built when
// SEQ_DIVIDER_SIGNED_EN is undefined; the signed scenarios when it is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ready;
    logic        div_by_zero;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_divider #(
        .WIDTH(8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start for one edge and counts the edges until ready rises.
    // Outputs are sampled on falling edges. rdy0/q0 are taken right after the
    // accepting edge.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          output int lat, output logic rdy0, output logic [7:0] q0);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdy0  = ready;
        q0    = quotient;
        lat   = 0;
        while (ready !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (quotient !== 8'h00) begin n_fail++;
            $display("FAIL reset_quotient: got %h want 00", quotient); end
        n_cmp++; if (remainder !== 8'h00) begin n_fail++;
            $display("FAIL reset_remainder: got %h want 00", remainder); end
        n_cmp++; if ({div_by_zero, overflow} !== 2'b00) begin n_fail++;
            $display("FAIL reset_flags: got %b want 00", {div_by_zero, overflow}); end
    endtask

    task automatic test_div_by_zero();
        int lat; logic rdy0; logic [7:0] q0;
        run_op(16'd55, 8'd0, lat, rdy0, q0);
        n_cmp++; if (rdy0 !== 1'b0) begin n_fail++;
            $display("FAIL dbz_busy: ready got %b want 0", rdy0); end
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL dbz_latency: got %0d want 1", lat); end
        n_cmp++; if (div_by_zero !== 1'b1 || overflow !== 1'b0) begin n_fail++;
            $display("FAIL dbz_flags: got dbz=%b ovf=%b want 1 0", div_by_zero, overflow); end
        n_cmp++; if (quotient !== 8'hFF) begin n_fail++;
            $display("FAIL dbz_quotient: got %h want ff", quotient); end
        n_cmp++; if (remainder !== 8'h37) begin n_fail++;
            $display("FAIL dbz_remainder: got %h want 37", remainder); end
    endtask

    task automatic test_preflight_overflow();
        int lat; logic rdy0; logic [7:0] q0;
        run_op(16'd2560, 8'd10, lat, rdy0, q0);
        // Previous operation left quotient=FF; it must hold until rewritten.
        n_cmp++; if (q0 !== 8'hFF) begin n_fail++;
            $display("FAIL pre_hold_quotient: got %h want ff", q0); end
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL pre_latency: got %0d want 1", lat); end
        n_cmp++; if (overflow !== 1'b1 || div_by_zero !== 1'b0) begin n_fail++;
            $display("FAIL pre_flags: got ovf=%b dbz=%b want 1 0", overflow, div_by_zero); end
        n_cmp++; if (quotient !== 8'hFF || remainder !== 8'h00) begin n_fail++;
            $display("FAIL pre_result: got q=%h r=%h want ff 00", quotient, remainder); end
    endtask

`ifndef SEQ_DIVIDER_SIGNED_EN
    task automatic test_basic();
        int lat; logic rdy0; logic [7:0] q0;
        run_op(16'd1000, 8'd7, lat, rdy0, q0);
        n_cmp++; if (rdy0 !== 1'b0) begin n_fail++;
            $display("FAIL basic_busy: ready got %b want 0", rdy0); end
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL basic_latency: got %0d want 9", lat); end
        n_cmp++; if (quotient !== 8'd142) begin n_fail++;
            $display("FAIL basic_quotient: got %0d want 142", quotient); end
        n_cmp++; if (remainder !== 8'd6) begin n_fail++;
            $display("FAIL basic_remainder: got %0d want 6", remainder); end
        n_cmp++; if ({div_by_zero, overflow} !== 2'b00) begin n_fail++;
            $display("FAIL basic_flags: got %b want 00", {div_by_zero, overflow}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int low;
        @(negedge clk);
        dividend = 16'd65025;
        divisor  = 8'd255;
        start    = 1'b1;
        @(negedge clk);
        // Next operand set presented while busy; start stays high throughout.
        dividend = 16'd100;
        divisor  = 8'd3;
        lat = 0;
        while (ready !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL b2b_first_latency: got %0d want 9", lat); end
        n_cmp++; if (quotient !== 8'd255 || remainder !== 8'd0) begin n_fail++;
            $display("FAIL b2b_first_result: got q=%0d r=%0d want 255 0", quotient, remainder); end
        @(negedge clk);
        low = 0;
        while (ready !== 1'b1 && low < 30) begin
            low++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (low !== 9) begin n_fail++;
            $display("FAIL b2b_ready_low_cycles: got %0d want 9", low); end
        n_cmp++; if (quotient !== 8'd33 || remainder !== 8'd1) begin n_fail++;
            $display("FAIL b2b_second_result: got q=%0d r=%0d want 33 1", quotient, remainder); end
    endtask

    task automatic test_ignored_start();
        int lat;
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'd50;
        divisor  = 8'd5;
        lat = 0;
        while (ready !== 1'b1 && lat < 30) begin
            // Pulses land on edges in RUN (k+3, k+6) and in FIX (k+9).
            start = (lat == 2 || lat == 5 || lat == 8);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL ignored_latency: got %0d want 9", lat); end
        n_cmp++; if (quotient !== 8'd142 || remainder !== 8'd6) begin n_fail++;
            $display("FAIL ignored_result: got q=%0d r=%0d want 142 6", quotient, remainder); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic rdy0; logic [7:0] q0;
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_fail++;
            $display("FAIL midrst_ready: got %b want 1", ready); end
        n_cmp++; if (quotient !== 8'h00 || remainder !== 8'h00) begin n_fail++;
            $display("FAIL midrst_result: got q=%h r=%h want 00 00", quotient, remainder); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_fail++;
            $display("FAIL midrst_stays_idle: ready got %b want 1", ready); end
        run_op(16'd1000, 8'd7, lat, rdy0, q0);
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL midrst_rerun_latency: got %0d want 9", lat); end
        n_cmp++; if (quotient !== 8'd142 || remainder !== 8'd6) begin n_fail++;
            $display("FAIL midrst_rerun_result: got q=%0d r=%0d want 142 6", quotient, remainder); end
    endtask
`else
    task automatic test_signed();
        int lat; logic rdy0; logic [7:0] q0;
        run_op(16'hFF9C, 8'd7, lat, rdy0, q0);       // -100 / 7
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL signed_neg_latency: got %0d want 9", lat); end
        n_cmp++; if (quotient !== 8'hF2 || remainder !== 8'hFE) begin n_fail++;
            $display("FAIL signed_neg_result: got q=%h r=%h want f2 fe", quotient, remainder); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++;
            $display("FAIL signed_neg_ovf: got %b want 0", overflow); end
        run_op(16'd200, 8'd1, lat, rdy0, q0);         // 200 / 1 overflows in FIX
        n_cmp++; if (lat !== 9) begin n_fail++;
            $display("FAIL signed_ovf_latency: got %0d want 9", lat); end
        n_cmp++; if (overflow !== 1'b1 || quotient !== 8'hFF || remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL signed_ovf_result: got ovf=%b q=%h r=%h want 1 ff 00",
                     overflow, quotient, remainder); end
        run_op(16'hFF80, 8'd1, lat, rdy0, q0);        // -128 / 1
        n_cmp++; if (quotient !== 8'h80 || overflow !== 1'b0) begin n_fail++;
            $display("FAIL signed_min_result: got q=%h ovf=%b want 80 0", quotient, overflow); end
        n_cmp++; if (remainder !== 8'h00) begin n_fail++;
            $display("FAIL signed_min_remainder: got %h want 00", remainder); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SEQ_DIVIDER_SIGNED_EN
        test_basic();
`endif
        test_div_by_zero();
        test_preflight_overflow();
`ifndef SEQ_DIVIDER_SIGNED_EN
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_op();
`else
        test_signed();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
